mem_initiator: RTL and testbench

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/mem_initiator_if.sv | 34 +++
 rtl/mem_initiator.sv | 134 +++++++++++++
 tb/tb_mem_initiator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_initiator_if.sv
// Bundle of the client command/response channels and the memory bus seen by mem_initiator.
// The master modport is the initiator's view. The slave modport is the view of the client and memory.
interface mem_initiator_if;
  // client command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [14:0] cmd_addr;
  logic [31:0] cmd_wdata;
  // client response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  // memory bus
  logic [14:0] addr;
  logic [31:0] wdata;
  logic        wr_rd;
  logic        valid;
  logic        ready;
  logic        error;
  logic [31:0] rdata;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, ready, error, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, addr, wdata, wr_rd, valid
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, ready, error, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, addr, wdata, wr_rd, valid
  );
endinterface

// File: rtl/mem_initiator.sv
// Single-outstanding memory bus initiator.
// The block accepts one client command and drives it onto the memory bus until ready arrives or the wait budget expires.
// It then holds the response until the client takes it.
// rst_n is active-high despite its name, and it is asynchronous.
module mem_initiator #(
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst_n,
  mem_initiator_if.master bus
);

  localparam int             CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state_q,       state_d;
  logic [CW-1:0] cnt_q,         cnt_d;
  logic          cmd_ready_q,   cmd_ready_d;
  logic          valid_q,       valid_d;
  logic          wr_rd_q,       wr_rd_d;
  logic [14:0]   addr_q,        addr_d;
  logic [31:0]   wdata_q,       wdata_d;
  logic          rsp_valid_q,   rsp_valid_d;
  logic [31:0]   rsp_rdata_q,   rsp_rdata_d;
  logic          rsp_error_q,   rsp_error_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  // Next-state and next-output logic for the IDLE -> REQ -> RESP transfer sequence.
  always_comb begin
    // NOTE: every _d starts from its _q so that no path leaves a variable unassigned; an unassigned path would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    valid_d       = valid_q;
    wr_rd_d       = wr_rd_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready is still low in the first cycle after reset. It goes high on the next edge.
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          wr_rd_d     = bus.cmd_wr;
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
          cnt_d       = '0;
          valid_d     = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = REQ;
        end
      end

      REQ: begin
        // Completion is tested before the budget, so a ready on the last wait cycle still counts as a normal completion.
        if (bus.ready) begin
          rsp_rdata_d   = wr_rd_q ? 32'h0 : bus.rdata;
          rsp_error_d   = bus.error;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          valid_d       = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d   = 32'h0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          valid_d       = 1'b0;
          state_d       = RESP;
        end else begin
          // The counter leaves REQ at CNT_LAST, so it never wraps.
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs. Reset clears them at once and aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      valid_q       <= 1'b0;
      wr_rd_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update together from values sampled before the edge.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      valid_q       <= valid_d;
      wr_rd_q       <= wr_rd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.valid       = valid_q;
  assign bus.wr_rd       = wr_rd_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Testbench for mem_initiator. It applies directed transfers: write, read, error, timeout, backpressure, the last-cycle boundary and reset mid-transfer.
// Expected responses go into a queue. A monitor compares them on each response handshake.
module tb_mem_initiator;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  rsp_t exp_q[$];

  mem_initiator_if bus ();

  mem_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor. It samples mid low-phase, after the driver has settled rsp_ready, and pops one expectation per handshake.
  always @(negedge clk) begin
    #2;
    if (!rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_fields", {30'd0, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout}, {30'd0, e});
      end
    end
  end

  // Runs one command.
  // delay = index of the valid cycle that returns ready; -1 means ready never comes.
  // hold = number of cycles rsp_ready is kept low.
  task automatic xfer(input logic wr, input logic [14:0] a, input logic [31:0] wd, input int delay,
                      input logic [31:0] rd, input logic er, input int hold, input int exp_cycles);
    rsp_t e;
    int   guard;
    int   cycles;
    e.timeout = (delay < 0);
    e.error   = e.timeout ? 1'b1 : er;
    e.rdata   = (e.timeout || wr) ? 32'h0 : rd;

    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_before", {63'd0, bus.cmd_ready}, 64'd1);
    exp_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom;

    cycles = 0;
    while (bus.valid && cycles < TIMEOUT + 8) begin
      check("bus_hold", {15'd0, bus.cmd_ready, bus.wr_rd, bus.addr, bus.wdata}, {15'd0, 1'b0, wr, a, wd});
      if (cycles == delay) begin
        bus.ready = 1'b1;
        bus.rdata = rd;
        bus.error = er;
      end else begin
        bus.ready = 1'b0;
        bus.rdata = $urandom;
        bus.error = 1'($urandom);
      end
      cycles++;
      @(negedge clk);
    end
    bus.ready = 1'b0;
    check("valid_cycles", 64'(cycles), 64'(exp_cycles));
    check("rsp_latency", {63'd0, bus.rsp_valid}, 64'd1);

    for (int i = 0; i < hold; i++) begin
      check("backpressure", {28'd0, bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout},
            {28'd0, 1'b1, 1'b0, e});
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_released", {63'd0, bus.rsp_valid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.ready     = 1'b0;
    bus.error     = 1'b0;
    bus.rdata     = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'd0, bus.cmd_ready, bus.valid, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout,
          bus.wr_rd, bus.addr, bus.wdata[0]}, 64'd0);
    check("reset_data", {bus.wdata, bus.rsp_rdata}, 64'd0);
    rst_n = 1'b0;
    #1 check("cmd_ready_pre_edge", {63'd0, bus.cmd_ready}, 64'd0);
    @(negedge clk);
    check("cmd_ready_after_rst", {63'd0, bus.cmd_ready}, 64'd1);

    // memory strobes while idle are ignored
    bus.ready = 1'b1;
    bus.error = 1'b1;
    bus.rdata = 32'h1111_2222;
    repeat (2) @(negedge clk);
    check("idle_ignore", {59'd0, bus.cmd_ready, bus.valid, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout},
          {59'd0, 5'b10000});
    bus.ready = 1'b0;
    bus.error = 1'b0;

    xfer(1'b1, 15'h0010, 32'hDEAD_BEEF,  2, 32'h1234_5678, 1'b0, 0, 3);          // write
    xfer(1'b0, 15'h0010, 32'h0,          0, 32'hDEAD_BEEF, 1'b0, 0, 1);          // read
    xfer(1'b0, 15'h7FFF, 32'h0,          1, 32'hCAFE_F00D, 1'b1, 0, 2);          // error
    xfer(1'b0, 15'h1234, 32'h0,         -1, 32'h0,         1'b0, 0, TIMEOUT);    // timeout
    xfer(1'b0, 15'h0042, 32'h0,          0, 32'hA5A5_A5A5, 1'b0, 5, 1);          // backpressure
    xfer(1'b1, 15'h0100, 32'h0102_0304, 15, 32'hFFFF_FFFF, 1'b0, 0, TIMEOUT);    // ready on last wait cycle
    xfer(1'b1, 15'h7FFF, 32'h5555_AAAA,  3, 32'h5555_5555, 1'b1, 2, 4);          // write with error

    // reset in the middle of REQ
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 15'h0AAA;
    bus.cmd_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("abort_valid_up", {63'd0, bus.valid}, 64'd1);
    #2 rst_n = 1'b1;
    #1 check("abort_async", {47'd0, bus.valid, bus.cmd_ready, bus.rsp_valid, bus.addr, 1'b0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_cmd_ready_low", {63'd0, bus.cmd_ready}, 64'd0);
    @(negedge clk);
    check("abort_recover", {62'd0, bus.cmd_ready, bus.rsp_valid}, {62'd0, 2'b10});
    repeat (2) @(negedge clk);
    check("abort_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);

    xfer(1'b0, 15'h0055, 32'h0,          1, 32'h7777_8888, 1'b0, 0, 2);          // recovery after abort

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
